// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits resolved CHUNK bits per stage behind a global-stall valid/ready pipe.
// Optional signed-overflow output is enabled by defining RCA_OVERFLOW_EN.
module pipelined_ripple_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef RCA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSTAGE = WIDTH / CHUNK;

  if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_width_check
    $error("pipelined_ripple_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  // One stall signal for the whole pipe; bubbles shift like beats.
  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    // Operand bits not yet consumed on entry to this stage, and sum bits resolved on exit.
    localparam int IW = WIDTH - k * CHUNK;
    localparam int SW = (k + 1) * CHUNK;

    logic [IW-1:0]  op_a;
    logic [IW-1:0]  op_b;
    logic           cin;
    logic           vin;
    logic [CHUNK:0] slice;
    logic [SW-1:0]  s_nxt;
    logic [SW-1:0]  s_q;
    logic           c_q;
    logic           v_q;

    if (k == 0) begin : g_head
      assign op_a  = A;
      assign op_b  = B ^ {WIDTH{sub}};
      assign cin   = sub | c_in;
      assign vin   = in_valid;
      assign s_nxt = slice[CHUNK-1:0];
    end else begin : g_body
      assign op_a  = g_stage[k-1].g_fwd.a_q;
      assign op_b  = g_stage[k-1].g_fwd.b_q;
      assign cin   = g_stage[k-1].c_q;
      assign vin   = g_stage[k-1].v_q;
      assign s_nxt = {slice[CHUNK-1:0], g_stage[k-1].s_q};
    end

    assign slice = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, cin};

    // NOTE: sequential state uses non-blocking assignments so every stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= vin;
        c_q <= slice[CHUNK];
        s_q <= s_nxt;
      end
    end

    if (k < NSTAGE - 1) begin : g_fwd
      logic [IW-CHUNK-1:0] a_q;
      logic [IW-CHUNK-1:0] b_q;

      // NOTE: forwarded operand slices carry no reset; they are only observed behind a valid stage flag.
      always_ff @(posedge clk) begin
        if (advance) begin
          a_q <= op_a[IW-1:CHUNK];
          b_q <= op_b[IW-1:CHUNK];
        end
      end
    end
  end

  assign out_valid = g_stage[NSTAGE-1].v_q;
  assign sum       = g_stage[NSTAGE-1].s_q;
  assign c_out     = g_stage[NSTAGE-1].c_q;

`ifdef RCA_OVERFLOW_EN
  // Carry into the MSB is recovered from the MSB sum bit: c_msb = a ^ b ^ s.
  logic ovf_nxt;
  assign ovf_nxt = g_stage[NSTAGE-1].slice[CHUNK]
                 ^ (g_stage[NSTAGE-1].op_a[CHUNK-1]
                  ^ g_stage[NSTAGE-1].op_b[CHUNK-1]
                  ^ g_stage[NSTAGE-1].slice[CHUNK-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (advance) begin
      ovf <= ovf_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed bench for pipelined_ripple_adder: 32/4 pipe (latency 8) and a 16/16 single-stage instance (latency 1).
// Define RCA_OVERFLOW_EN on both bench and design to exercise the overflow output.
module tb_pipelined_ripple_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        c_in, sub, c_out;
  logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s;
  logic [15:0] a_s, b_s, sum_s;
  logic        c_in_s, sub_s, c_out_s;
`ifdef RCA_OVERFLOW_EN
  logic        ovf, ovf_s;
`endif

  int checks = 0;
  int errors = 0;

  pipelined_ripple_adder #(.WIDTH(32), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out)
`ifdef RCA_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  pipelined_ripple_adder #(.WIDTH(16), .CHUNK(16)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .A(a_s), .B(b_s), .c_in(c_in_s), .sub(sub_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .sum(sum_s), .c_out(c_out_s)
`ifdef RCA_OVERFLOW_EN
    , .ovf(ovf_s)
`endif
  );

  // Reference: {ovf, c_out, sum} from a 33-bit add of the effective operands.
  function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic cv, input logic sv);
    logic [31:0] be;
    logic [32:0] r;
    logic        ov;
    be = sv ? ~bv : bv;
    r  = {1'b0, av} + {1'b0, be} + {32'd0, (sv ? 1'b1 : cv)};
    ov = (av[31] == be[31]) && (r[31] != av[31]);
    return {ov, r};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
  endtask

  // Presents one beat, then waits (bounded) for its result; lat = clock edges until out_valid, -1 on timeout.
  task automatic single_op(input logic [31:0] av, input logic [31:0] bv, input logic cv, input logic sv,
                           output logic [31:0] s, output logic co, output logic ov, output int lat);
    out_ready = 1'b1;
    in_valid = 1'b1; a = av; b = bv; c_in = cv; sub = sv;
    lat = -1; s = '0; co = 1'b0; ov = 1'b0;
    tick();
    idle_inputs();
    for (int i = 1; i <= 20; i++) begin
      if (out_valid) begin
        lat = i; s = sum; co = c_out;
`ifdef RCA_OVERFLOW_EN
        ov = ovf;
`endif
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); out_ready = 1'b1;
    in_valid_s = 1'b0; a_s = '0; b_s = '0; c_in_s = 1'b0; sub_s = 1'b0; out_ready_s = 1'b1;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || sum !== 32'd0 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: out_valid=%b sum=%h c_out=%b, expected 0/0/0", out_valid, sum, c_out);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || sum !== 32'd0 || c_out !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: out_valid=%b sum=%h c_out=%b in_ready=%b, expected 0/0/0/1",
                 i, out_valid, sum, c_out, in_ready);
      end
    end
  endtask

  task automatic test_carry_ripple();
    logic [31:0] s; logic co, ov; int lat;
    single_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, s, co, ov, lat);
    checks++;
    if (lat !== 8 || s !== 32'h0 || co !== 1'b1) begin
      errors++;
      $display("FAIL full_ripple: lat=%0d sum=%h c_out=%b, expected 8/00000000/1", lat, s, co);
    end
    single_op(32'h0000_000F, 32'h1, 1'b0, 1'b0, s, co, ov, lat);
    checks++;
    if (s !== 32'h10 || co !== 1'b0) begin
      errors++;
      $display("FAIL slice_carry: sum=%h c_out=%b, expected 00000010/0", s, co);
    end
    single_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, s, co, ov, lat);
    checks++;
    if (s !== 32'hFFFF_FFFF || co !== 1'b1) begin
      errors++;
      $display("FAIL wrap_max: sum=%h c_out=%b, expected ffffffff/1", s, co);
    end
  endtask

  task automatic test_subtract();
    logic [31:0] s; logic co, ov; int lat;
    single_op(32'd5, 32'd7, 1'b1, 1'b1, s, co, ov, lat);
    checks++;
    if (s !== 32'hFFFF_FFFE || co !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: sum=%h c_out=%b, expected fffffffe/0", s, co);
    end
    single_op(32'd7, 32'd5, 1'b0, 1'b1, s, co, ov, lat);
    checks++;
    if (s !== 32'd2 || co !== 1'b1) begin
      errors++;
      $display("FAIL sub_no_borrow: sum=%h c_out=%b, expected 00000002/1", s, co);
    end
    single_op(32'd0, 32'd0, 1'b0, 1'b1, s, co, ov, lat);
    checks++;
    if (s !== 32'd0 || co !== 1'b1) begin
      errors++;
      $display("FAIL sub_zero: sum=%h c_out=%b, expected 00000000/1", s, co);
    end
`ifdef RCA_OVERFLOW_EN
    single_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, s, co, ov, lat);
    checks++;
    if (s !== 32'h8000_0000 || ov !== 1'b1) begin
      errors++;
      $display("FAIL ovf_add: sum=%h ovf=%b, expected 80000000/1", s, ov);
    end
    single_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, s, co, ov, lat);
    checks++;
    if (s !== 32'h7FFF_FFFF || ov !== 1'b1 || co !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sub: sum=%h ovf=%b c_out=%b, expected 7fffffff/1/1", s, ov, co);
    end
    single_op(32'd1, 32'd1, 1'b0, 1'b0, s, co, ov, lat);
    checks++;
    if (s !== 32'd2 || ov !== 1'b0) begin
      errors++;
      $display("FAIL ovf_none: sum=%h ovf=%b, expected 00000002/0", s, ov);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp_r [100];
    logic [33:0] m;
    int nout = 0, first = -1, last = -1, drops = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 130; cyc++) begin
      if (cyc < 100) begin
        a = $urandom; b = $urandom; c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        m = model(a, b, c_in, sub);
        exp_r[cyc] = m;
      end else begin
        idle_inputs();
      end
      if (in_ready !== 1'b1) drops++;
      if (out_valid === 1'b1) begin
        checks++;
        if (nout >= 100) begin
          errors++;
          $display("FAIL b2b_extra: unexpected result %0d sum=%h", nout, sum);
        end else if (sum !== exp_r[nout][31:0] || c_out !== exp_r[nout][32]) begin
          errors++;
          $display("FAIL b2b_result %0d: sum=%h c_out=%b, expected %h/%b",
                   nout, sum, c_out, exp_r[nout][31:0], exp_r[nout][32]);
        end
        if (first < 0) first = cyc;
        last = cyc;
        nout++;
      end
      tick();
    end
    checks++;
    if (nout != 100 || first != 8 || last - first != 99) begin
      errors++;
      $display("FAIL b2b_stream: results=%0d first=%0d span=%0d, expected 100/8/99", nout, first, last - first);
    end
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL b2b_in_ready: low for %0d cycles, expected 0", drops);
    end
  endtask

  task automatic test_stall();
    logic [31:0] va [20], vb [20];
    logic        vc [20], vs [20];
    logic [33:0] exp_r [20];
    int idx = 0, nout = 0, low = 0;
    for (int i = 0; i < 20; i++) begin
      va[i] = 32'h0123_4567 * (i + 1);
      vb[i] = 32'h89AB_CDEF ^ (32'h0101_0101 * i);
      vc[i] = 1'(i);
      vs[i] = 1'(i >> 1);
      exp_r[i] = model(va[i], vb[i], vc[i], vs[i]);
    end
    for (int cyc = 0; cyc < 60; cyc++) begin
      out_ready = !(cyc >= 12 && cyc < 17);
      if (idx < 20) begin
        in_valid = 1'b1; a = va[idx]; b = vb[idx]; c_in = vc[idx]; sub = vs[idx];
      end else begin
        idle_inputs();
      end
      #1;
      if (in_ready !== 1'b1) low++;
      if (cyc >= 12 && cyc < 17) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || nout >= 20 || sum !== exp_r[nout][31:0]) begin
          errors++;
          $display("FAIL stall_hold cycle %0d: in_ready=%b out_valid=%b sum=%h", cyc, in_ready, out_valid, sum);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (nout >= 20) begin
          errors++;
          $display("FAIL stall_extra: unexpected result sum=%h", sum);
        end else if (sum !== exp_r[nout][31:0] || c_out !== exp_r[nout][32]) begin
          errors++;
          $display("FAIL stall_result %0d: sum=%h c_out=%b, expected %h/%b",
                   nout, sum, c_out, exp_r[nout][31:0], exp_r[nout][32]);
        end
        nout++;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    checks++;
    if (low != 5 || nout != 20 || idx != 20) begin
      errors++;
      $display("FAIL stall_stream: in_ready low %0d, results %0d, accepted %0d, expected 5/20/20", low, nout, idx);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] s; logic co, ov; int lat; int seen = 0; int stale = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = (i == 0) ? 32'hFFFF_FFFF : 32'(i); b = 32'd2; c_in = 1'b0; sub = 1'b0;
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    checks++;
    if (out_valid !== 1'b1 || sum !== 32'd1 || c_out !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_head: out_valid=%b sum=%h c_out=%b, expected 1/00000001/1", out_valid, sum, c_out);
    end
    #2 rst_n = 1'b0;
    #1;
    seen = out_valid | c_out | (|sum);
`ifdef RCA_OVERFLOW_EN
    seen = seen | ovf;
`endif
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL async_clear: out_valid=%b sum=%h c_out=%b, expected 0/0/0", out_valid, sum, c_out);
    end
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL stale_beat: out_valid seen %0d cycles after reset, expected 0", stale);
    end
    single_op(32'd3, 32'd4, 1'b0, 1'b0, s, co, ov, lat);
    checks++;
    if (lat !== 8 || s !== 32'd7 || co !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_beat: lat=%0d sum=%h c_out=%b, expected 8/00000007/0", lat, s, co);
    end
  endtask

  task automatic test_single_stage();
    logic [15:0] ta [4], tb [4], es [4];
    logic        tc [4], ts [4], ec [4], eo [4];
    ta = '{16'hFFFF, 16'h1234, 16'h0005, 16'h8000};
    tb = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
    tc = '{1'b0, 1'b1, 1'b0, 1'b0};
    ts = '{1'b0, 1'b0, 1'b1, 1'b1};
    es = '{16'h0000, 16'h1236, 16'hFFFE, 16'h7FFF};
    ec = '{1'b1, 1'b0, 1'b0, 1'b1};
    eo = '{1'b0, 1'b0, 1'b0, 1'b1};
    out_ready_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid_s = 1'b1; a_s = ta[i]; b_s = tb[i]; c_in_s = tc[i]; sub_s = ts[i];
      tick();
      checks++;
      if (out_valid_s !== 1'b1 || sum_s !== es[i] || c_out_s !== ec[i]) begin
        errors++;
        $display("FAIL single_stage %0d: out_valid=%b sum=%h c_out=%b, expected 1/%h/%b",
                 i, out_valid_s, sum_s, c_out_s, es[i], ec[i]);
      end
`ifdef RCA_OVERFLOW_EN
      checks++;
      if (ovf_s !== eo[i]) begin
        errors++;
        $display("FAIL single_stage_ovf %0d: ovf=%b, expected %b", i, ovf_s, eo[i]);
      end
`endif
    end
    in_valid_s = 1'b0; out_ready_s = 1'b0;
    #1;
    tick();
    checks++;
    if (in_ready_s !== 1'b0 || out_valid_s !== 1'b1 || sum_s !== 16'h7FFF) begin
      errors++;
      $display("FAIL single_stage_stall: in_ready=%b out_valid=%b sum=%h, expected 0/1/7fff",
               in_ready_s, out_valid_s, sum_s);
    end
    out_ready_s = 1'b1;
    tick();
    checks++;
    if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin
      errors++;
      $display("FAIL single_stage_drain: out_valid=%b in_ready=%b, expected 0/1", out_valid_s, in_ready_s);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_carry_ripple();
    test_subtract();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_single_stage();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
